fb_sweep_issuer: RTL and testbench



---
 rtl/fb_sweep_issuer_pkg.sv | 42 ++++
 rtl/fb_sweep_issuer_xy_scan_counter.sv | 37 +++
 rtl/fb_sweep_issuer.sv | 110 +++++++++++
 tb/tb_fb_sweep_issuer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sweep_issuer_pkg.sv
// Shared instruction-port constants for the framebuffer sweep issuer and its
// helpers: field layout, opcodes and an instruction builder.
package fb_sweep_issuer_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int OPCODE_WIDTH      = 4;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int COLOUR_WIDTH      = 3;

  localparam int OPCODE_LSB = 0;
  localparam int X_LSB      = 4;
  localparam int Y_LSB      = 12;
  localparam int COLOUR_LSB = 19;
  localparam int WE_BIT     = 22;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OPCODE_NOP     = 4'h0,
    OPCODE_DISPLAY = 4'h1,
    OPCODE_DRAW    = 4'h2
  } opcode_e;

  // Refresh emits a bare DISPLAY; clear emits DRAW with colour and write enable.
  function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(
    input logic                     clear_mode,
    input logic [X_COORD_WIDTH-1:0] x,
    input logic [Y_COORD_WIDTH-1:0] y,
    input logic [COLOUR_WIDTH-1:0]  colour
  );
    logic [INSTRUCTION_WIDTH-1:0] i;
    i = '0;
    i[OPCODE_LSB +: OPCODE_WIDTH] = clear_mode ? OPCODE_DRAW : OPCODE_DISPLAY;
    i[X_LSB +: X_COORD_WIDTH]     = x;
    i[Y_LSB +: Y_COORD_WIDTH]     = y;
    if (clear_mode) begin
      i[COLOUR_LSB +: COLOUR_WIDTH] = colour;
      i[WE_BIT]                     = 1'b1;
    end
    return i;
  endfunction

endpackage

// File: rtl/fb_sweep_issuer_xy_scan_counter.sv
// Row-major pixel coordinate counter: x fastest, wraps into y; flags the last
// pixel of the frame.
module xy_scan_counter
  import fb_sweep_issuer_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     advance,
  output logic [X_COORD_WIDTH-1:0] x,
  output logic [Y_COORD_WIDTH-1:0] y,
  output logic                     last
);

  localparam logic [X_COORD_WIDTH-1:0] X_LAST = X_COORD_WIDTH'(SCREEN_W - 1);
  localparam logic [Y_COORD_WIDTH-1:0] Y_LAST = Y_COORD_WIDTH'(SCREEN_H - 1);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/fb_sweep_issuer.sv
// Walks every framebuffer pixel and issues one DISPLAY (refresh) or DRAW
// (clear) instruction per pixel over the datapath start/finished handshake.
module fb_sweep_issuer
  import fb_sweep_issuer_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         go,
  input  logic                         mode,
  input  logic [COLOUR_WIDTH-1:0]      clear_colour,
  input  logic                         abort,
  input  logic                         dp_finished,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_DONE
  } state_e;

  state_e                         state, state_n;
  logic                           mode_q, mode_n;
  logic [COLOUR_WIDTH-1:0]        colour_q, colour_n;
  logic                           start_n, busy_n, done_n, aborted_n;
  logic [INSTRUCTION_WIDTH-1:0]   instr_n;
  logic                           scan_clear, scan_advance, last;
  logic [X_COORD_WIDTH-1:0]       x;
  logic [Y_COORD_WIDTH-1:0]       y;

  xy_scan_counter #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (scan_clear),
    .advance (scan_advance),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_comb begin
    state_n      = state;
    mode_n       = mode_q;
    colour_n     = colour_q;
    start_n      = 1'b0;
    done_n       = 1'b0;
    busy_n       = busy;
    aborted_n    = aborted;
    instr_n      = dp_instruction;
    scan_clear   = 1'b0;
    scan_advance = 1'b0;
    case (state)
      S_IDLE: if (go) begin
        mode_n     = mode;
        colour_n   = clear_colour;
        scan_clear = 1'b1;
        busy_n     = 1'b1;
        aborted_n  = 1'b0;
        state_n    = S_ISSUE;
      end
      S_ISSUE: if (dp_finished) begin
        start_n = 1'b1;
        instr_n = make_instr(mode_q, x, y, colour_q);
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK:  if (!dp_finished) state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (dp_finished)  state_n = S_NEXT;
      // Abort is honoured only here, so an issued pixel always runs to completion.
      S_NEXT: if (abort || last) begin
        done_n    = 1'b1;
        busy_n    = 1'b0;
        aborted_n = abort;
        state_n   = S_DONE;
      end else begin
        scan_advance = 1'b1;
        state_n      = S_ISSUE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      colour_q       <= '0;
      dp_start       <= 1'b0;
      dp_instruction <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      state          <= state_n;
      mode_q         <= mode_n;
      colour_q       <= colour_n;
      dp_start       <= start_n;
      dp_instruction <= instr_n;
      busy           <= busy_n;
      done           <= done_n;
      aborted        <= aborted_n;
    end
  end

endmodule

// File: tb/tb_fb_sweep_issuer.sv
// Scoreboard bench for fb_sweep_issuer on a 4x3 screen with a datapath model
// that drops finished for 3 cycles after each start.
module tb_fb_sweep_issuer;

  localparam int W = 4;
  localparam int H = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  clear_colour = 3'b000;
  logic        abort = 1'b0;
  logic        dp_finished;
  logic        dp_start;
  logic [31:0] dp_instruction;
  logic        busy, done, aborted;

  fb_sweep_issuer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .go             (go),
    .mode           (mode),
    .clear_colour   (clear_colour),
    .abort          (abort),
    .dp_finished    (dp_finished),
    .dp_start       (dp_start),
    .dp_instruction (dp_instruction),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  always #5 clock = ~clock;

  // Datapath model: ignores resetn so an in-flight instruction finishes alone.
  int   dp_cnt = 0;
  logic hold_low = 1'b0;
  always @(posedge clock) begin
    if (dp_start)         dp_cnt <= 3;
    else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
  end
  assign dp_finished = (dp_cnt == 0) && !hold_low;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_done   = 0;
  logic [31:0] exp_q[$];
  logic        exp_done_q[$];
  logic        prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] exp_instr(input logic m, input int x, input int y,
                                            input logic [2:0] c);
    logic [31:0] r;
    r = '0;
    r[3:0]   = m ? 4'h2 : 4'h1;
    r[11:4]  = x[7:0];
    r[18:12] = y[6:0];
    if (m) begin
      r[21:19] = c;
      r[22]    = 1'b1;
    end
    return r;
  endfunction

  task automatic push_sweep(input logic m, input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_instr(m, i % W, i / W, c));
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes start or done.
  always @(negedge clock) begin
    if (dp_start) begin
      chk("start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_start: got instr %h want no strobe", dp_instruction);
      end else begin
        chk("instr", dp_instruction, exp_q.pop_front());
      end
      n_starts++;
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        chk("aborted_at_done", {31'd0, aborted}, {31'd0, exp_done_q.pop_front()});
      end
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      n_done++;
    end
    prev_start = dp_start;
  end

  task automatic pulse_go(input logic m, input logic [2:0] c);
    mode = m;
    clear_colour = c;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (n_done == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done want done within 400 cycles", name);
    end
  endtask

  task automatic wait_starts(input string name, input int target);
    int k;
    k = 0;
    while (n_starts < target && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (n_starts < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d starts want %0d", name, n_starts, target);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_start"}, {31'd0, dp_start}, 32'd0);
    chk({name, "_instr"}, dp_instruction, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_aborted"}, {31'd0, aborted}, 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Refresh sweep with go-to-start latency check.
    base = n_starts;
    push_sweep(1'b0, 3'b000, W*H);
    exp_done_q.push_back(1'b0);
    pulse_go(1'b0, 3'b000);
    chk("go_busy", {31'd0, busy}, 32'd1);
    chk("go_lat1_start", {31'd0, dp_start}, 32'd0);
    @(negedge clock);
    chk("go_lat2_start", {31'd0, dp_start}, 32'd1);
    wait_done("refresh");
    chk("refresh_count", n_starts - base, W*H);
    chk("refresh_aborted", {31'd0, aborted}, 32'd0);

    // Clear sweep.
    base = n_starts;
    push_sweep(1'b1, 3'b101, W*H);
    exp_done_q.push_back(1'b0);
    pulse_go(1'b1, 3'b101);
    wait_done("clear");
    chk("clear_count", n_starts - base, W*H);

    // Abort during pixel (1,1): that pixel completes, then stop.
    base = n_starts;
    push_sweep(1'b0, 3'b000, 6);
    exp_done_q.push_back(1'b1);
    pulse_go(1'b0, 3'b000);
    wait_starts("abort", base + 6);
    abort = 1'b1;
    wait_done("abort");
    abort = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_count", n_starts - base, 6);
    chk("abort_sticky", {31'd0, aborted}, 32'd1);

    // finished held low at go: nothing issued until it rises.
    base = n_starts;
    hold_low = 1'b1;
    push_sweep(1'b1, 3'b010, W*H);
    exp_done_q.push_back(1'b0);
    pulse_go(1'b1, 3'b010);
    chk("go_clears_aborted", {31'd0, aborted}, 32'd0);
    repeat (9) @(negedge clock);
    chk("hold_no_start", n_starts - base, 0);
    hold_low = 1'b0;
    wait_done("hold");
    chk("hold_count", n_starts - base, W*H);

    // Reset mid-sweep after pixel 5 is issued.
    base = n_done;
    push_sweep(1'b0, 3'b000, 6);
    pulse_go(1'b0, 3'b000);
    wait_starts("midreset", n_starts + 6);
    resetn = 1'b0;
    @(negedge clock);
    chk_outputs_zero("midreset");
    resetn = 1'b1;
    repeat (15) @(negedge clock);
    chk("midreset_no_done", n_done - base, 0);
    chk("midreset_leftover", exp_q.size(), 0);

    // Restart after reset begins at (0,0).
    base = n_starts;
    push_sweep(1'b0, 3'b000, W*H);
    exp_done_q.push_back(1'b0);
    pulse_go(1'b0, 3'b000);
    wait_done("restart");
    chk("restart_count", n_starts - base, W*H);

    // Second go and mode/colour change mid-sweep are ignored.
    base = n_starts;
    push_sweep(1'b0, 3'b000, W*H);
    exp_done_q.push_back(1'b0);
    pulse_go(1'b0, 3'b000);
    wait_starts("busy_go", base + 3);
    pulse_go(1'b1, 3'b111);
    mode = 1'b0;
    wait_done("busy_go");
    repeat (10) @(negedge clock);
    chk("busy_go_count", n_starts - base, W*H);
    chk("busy_go_idle", {31'd0, busy}, 32'd0);
    chk("scoreboard_empty", exp_q.size() + exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
